// File: rtl/nand_cpu_pkg.sv
// rtl/nand_cpu_pkg.sv - shared types for the nand_cpu memory-access stage
package nand_cpu_pkg;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 4;

    // Memory-access stage sequencing
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_t;

    // Packet driven into the register-file write port
    typedef struct packed {
        logic               valid;
        logic               use_rw;
        logic [RADDR_W-1:0] rw_addr;
        logic [DATA_W-1:0]  data;
    } wb_pkt_t;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// rtl/dmem_timeout_ctr.sv - saturating wait counter that flags the last allowed ACCESS cycle
module dmem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int               CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Count waited cycles; clear wins over enable, and the count parks at TIMEOUT instead of wrapping
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != C_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // High during the final cycle an access may wait before it is aborted
    assign o_expired = (r_count == C_LAST);

endmodule

// File: rtl/d_mem_ctrl.sv
// rtl/d_mem_ctrl.sv - load/store memory stage: req/ack to data memory, stall and writeback packet
module d_mem_ctrl #(
    parameter int DATA_W  = nand_cpu_pkg::DATA_W,
    parameter int RADDR_W = nand_cpu_pkg::RADDR_W,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               in_valid,
    input  logic               in_load,
    input  logic               in_store,
    input  logic [DATA_W-1:0]  in_addr,
    input  logic [DATA_W-1:0]  in_wdata,
    input  logic [RADDR_W-1:0] in_rw_addr,
    output logic               stall,
    output logic               mem_req,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               wb_valid,
    output logic               wb_use_rw,
    output logic [RADDR_W-1:0] wb_rw_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               err
);

    import nand_cpu_pkg::*;

    dmem_state_t        r_state;
    dmem_state_t        w_next_state;

    logic               w_open;
    logic               w_accept;
    logic               w_illegal;
    logic               w_cnt_en;
    logic               w_expired;

    logic [DATA_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_we;
    logic [RADDR_W-1:0] r_rw_addr;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_abort;
    logic               r_ill_err;

    wb_pkt_t            w_wb;

    // A new op is only looked at when no access is outstanding
    assign w_open    = (r_state == IDLE) || (r_state == RESP);
    assign w_accept  = w_open && in_valid && (in_load ^ in_store);
    assign w_illegal = w_open && in_valid && in_load && in_store;

    // The wait counter only advances on ACCESS cycles that did not see an ack
    assign w_cnt_en  = (r_state == ACCESS) && !mem_ack;

    dmem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_clr     (w_accept),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: accept from IDLE/RESP, leave ACCESS on ack or on the last allowed wait cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, RESP: begin
                w_next_state = w_accept ? ACCESS : IDLE;
            end
            ACCESS: begin
                if (mem_ack || w_expired) begin
                    w_next_state = RESP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs: request while ACCESS, one-cycle writeback packet in RESP, stall on accept or ACCESS
    always_comb begin
        w_wb    = '0;
        mem_req = 1'b0;
        stall   = w_accept;
        err     = r_ill_err;
        case (r_state)
            ACCESS: begin
                mem_req = 1'b1;
                stall   = 1'b1;
            end
            RESP: begin
                w_wb.valid   = 1'b1;
                w_wb.rw_addr = r_rw_addr;
                w_wb.use_rw  = !r_we && !r_abort;
                w_wb.data    = (!r_we && !r_abort) ? r_rdata : '0;
                err          = r_ill_err || r_abort;
            end
            default: begin
            end
        endcase
    end

    // Latch the op on accept; these stay stable for the whole ACCESS phase
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_we        <= 1'b0;
            r_rw_addr   <= '0;
        end else if (w_accept) begin
            r_mem_addr  <= in_addr;
            r_mem_wdata <= in_wdata;
            r_we        <= in_store;
            r_rw_addr   <= in_rw_addr;
        end
    end

    // Capture load data on the ack edge and remember whether ACCESS ended by abort
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_rdata <= '0;
            r_abort <= 1'b0;
        end else if (r_state == ACCESS) begin
            if (mem_ack && !r_we) begin
                r_rdata <= mem_rdata;
            end
            r_abort <= !mem_ack && w_expired;
        end
    end

    // An illegal op (load and store together) reports err one cycle later
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_ill_err <= 1'b0;
        end else begin
            r_ill_err <= w_illegal;
        end
    end

    assign mem_we     = r_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign wb_valid   = w_wb.valid;
    assign wb_use_rw  = w_wb.use_rw;
    assign wb_rw_addr = w_wb.rw_addr;
    assign wb_data    = w_wb.data;

endmodule

// File: tb/tb_d_mem_ctrl.sv
// tb/tb_d_mem_ctrl.sv - transaction-level randomized bench for d_mem_ctrl
module tb_d_mem_ctrl;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          in_valid, in_load, in_store;
    logic [DW-1:0] in_addr, in_wdata;
    logic [AW-1:0] in_rw_addr;
    logic          stall, mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          wb_valid, wb_use_rw;
    logic [AW-1:0] wb_rw_addr;
    logic [DW-1:0] wb_data;
    logic          err;

    always #5 clk = ~clk;

    d_mem_ctrl #(
        .DATA_W  (DW),
        .RADDR_W (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .in_valid   (in_valid),
        .in_load    (in_load),
        .in_store   (in_store),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .in_rw_addr (in_rw_addr),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_use_rw  (wb_use_rw),
        .wb_rw_addr (wb_rw_addr),
        .wb_data    (wb_data),
        .err        (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected writeback owed in the coming cycle, and err owed by an illegal op
    bit            pend_resp = 1'b0;
    bit            pr_abort, pr_use_rw;
    logic [AW-1:0] pr_rw;
    logic [DW-1:0] pr_data;
    bit            ill_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input string ph, input bit exp_stall, input bit exp_req);
        bit exp_err;
        exp_err = ill_prev || (pend_resp && pr_abort);
        chk({ph, ".stall"},    32'(stall),    32'(exp_stall));
        chk({ph, ".mem_req"},  32'(mem_req),  32'(exp_req));
        chk({ph, ".err"},      32'(err),      32'(exp_err));
        chk({ph, ".wb_valid"}, 32'(wb_valid), 32'(pend_resp));
        if (pend_resp) begin
            chk({ph, ".wb_use_rw"},  32'(wb_use_rw),  32'(pr_use_rw));
            chk({ph, ".wb_rw_addr"}, 32'(wb_rw_addr), 32'(pr_rw));
            chk({ph, ".wb_data"},    32'(wb_data),    32'(pr_data));
        end
        pend_resp = 1'b0;
        ill_prev  = 1'b0;
    endtask

    task automatic chk_zero(input string ph);
        chk({ph, ".stall"},      32'(stall),      32'd0);
        chk({ph, ".mem_req"},    32'(mem_req),    32'd0);
        chk({ph, ".mem_we"},     32'(mem_we),     32'd0);
        chk({ph, ".mem_addr"},   32'(mem_addr),   32'd0);
        chk({ph, ".mem_wdata"},  32'(mem_wdata),  32'd0);
        chk({ph, ".wb_valid"},   32'(wb_valid),   32'd0);
        chk({ph, ".wb_use_rw"},  32'(wb_use_rw),  32'd0);
        chk({ph, ".wb_rw_addr"}, 32'(wb_rw_addr), 32'd0);
        chk({ph, ".wb_data"},    32'(wb_data),    32'd0);
        chk({ph, ".err"},        32'(err),        32'd0);
    endtask

    // One cycle without an acceptable op; ld&st together is the illegal case
    task automatic idle_cycle(input bit v, input bit ld, input bit st, input bit ack);
        in_valid   = v;
        in_load    = ld;
        in_store   = st;
        in_addr    = 16'($urandom);
        in_wdata   = 16'($urandom);
        in_rw_addr = 4'($urandom);
        mem_ack    = ack;
        mem_rdata  = 16'($urandom);
        @(negedge clk);
        check_cycle("idle", 1'b0, 1'b0);
        ill_prev = v && ld && st;
        tick();
        mem_ack  = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic rand_idle();
        int k;
        k = $urandom_range(0, 5);
        if (k == 0)      idle_cycle(1'b1, 1'b1, 1'b1, 1'($urandom));
        else if (k <= 2) idle_cycle(1'b1, 1'b0, 1'b0, 1'($urandom));
        else             idle_cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Whole transaction: accept, wait dly cycles for ack (abort once TO cycles have passed), then owe a RESP
    task automatic do_op(input bit st, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                         input logic [AW-1:0] rw, input int dly, input logic [DW-1:0] rd);
        int n;
        bit ab;
        in_valid   = 1'b1;
        in_load    = !st;
        in_store   = st;
        in_addr    = a;
        in_wdata   = wd;
        in_rw_addr = rw;
        mem_ack    = 1'($urandom);
        mem_rdata  = 16'($urandom);
        @(negedge clk);
        check_cycle("accept", 1'b1, 1'b0);
        tick();
        ab = (dly >= TO);
        n  = ab ? TO : dly + 1;
        for (int i = 0; i < n; i++) begin
            in_valid   = 1'($urandom);
            in_load    = 1'($urandom);
            in_store   = 1'($urandom);
            in_addr    = 16'($urandom);
            in_wdata   = 16'($urandom);
            in_rw_addr = 4'($urandom);
            mem_ack    = (i == dly);
            mem_rdata  = (i == dly) ? rd : 16'($urandom);
            @(negedge clk);
            check_cycle("access", 1'b1, 1'b1);
            chk("access.mem_we",    32'(mem_we),    32'(st));
            chk("access.mem_addr",  32'(mem_addr),  32'(a));
            chk("access.mem_wdata", 32'(mem_wdata), 32'(wd));
            tick();
        end
        in_valid  = 1'b0;
        mem_ack   = 1'b0;
        pend_resp = 1'b1;
        pr_abort  = ab;
        pr_use_rw = !st && !ab;
        pr_data   = pr_use_rw ? rd : '0;
        pr_rw     = rw;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        in_addr = '0; in_wdata = '0; in_rw_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        @(negedge clk);
        chk_zero("reset");
        tick();
        n_rst = 1'b1;

        // Load, ack on first req cycle
        do_op(1'b0, 16'h1234, 16'h0000, 4'd5, 0, 16'hBEEF);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        // Store, ack after 3 wait cycles
        do_op(1'b1, 16'h0010, 16'hA5A5, 4'd2, 3, 16'h0000);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        // Timeout abort, then a stray ack
        do_op(1'b0, 16'h2222, 16'h0000, 4'd7, TO + 2, 16'h5555);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        // Back-to-back loads, second accepted in RESP of the first
        do_op(1'b0, 16'h3000, 16'h0000, 4'd1, 0, 16'h1111);
        do_op(1'b0, 16'h3002, 16'h0000, 4'd2, 1, 16'h2222);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        // Illegal op, and a no-op valid
        idle_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        idle_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in mid-ACCESS, then a late ack
        in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0;
        in_addr = 16'h4444; in_wdata = 16'h0; in_rw_addr = 4'd3;
        @(negedge clk);
        check_cycle("rst_accept", 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        n_rst    = 1'b0;
        @(negedge clk);
        chk("rst_pre.mem_req", 32'(mem_req), 32'd1);
        tick();
        n_rst     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        chk_zero("after_rst");
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        check_cycle("late_ack", 1'b0, 1'b0);
        tick();

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) rand_idle();
            do_op(1'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
                  $urandom_range(0, TO + 1), 16'($urandom));
        end
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
